shift_right_seq: RTL and testbench
==================================

Name: shift_right_seq

Overview:
Iterative 16-bit right shifter. It is the right-direction counterpart of the combinational left-shift stages used by the ALU.
- Performs logical right shift (SRL), arithmetic right shift (SRA) or rotate right (ROR) by 0..15.
- Applies one binary shift stage (8, 4, 2, 1) per clock.
- Uses a start/busy/done handshake, so the execute stage can use it as a multi-cycle functional unit without a wide combinational shifter on the critical path.

Parameters:
none (datapath fixed at 16 bits, 4 stages)

Ports:
clk    input   1   system clock, rising-edge
rst    input   1   asynchronous, active-high reset
start  input   1   request; sampled only in IDLE
In     input   16  operand, captured on accepted start
Cnt    input   4   shift amount 0..15, captured on accepted start
Mode   input   2   00 SRL, 01 SRA, 10 ROR, 11 treated as SRL; captured on accepted start
Out    output  16  result register; holds last result until the next completion
busy   output  1   high while an operation is in progress
done   output  1   one-cycle pulse; Out valid from this cycle onward

Behaviour:
- Clock and reset: one clock domain (clk); rst is asynchronous and active-high.
- Reset values: state=IDLE, stage=3, work=0, Out=0x0000, busy=0, done=0. Reset takes effect immediately, independent of clk.
- Reset mid-operation: abandons the operation, with no done pulse. Out returns to 0.
- State machine: IDLE and SHIFT, plus a 2-bit stage index (3 down to 0).
- IDLE: if start=1 at edge E0:
  - work<=In, cnt_r<=Cnt, mode_r<=Mode.
  - stage<=3, state<=SHIFT, busy<=1.
  - Otherwise stay in IDLE.
- SHIFT, at each edge E1..E4 (stage 3,2,1,0):
  - if cnt_r[stage]=1, work <= work shifted right by 2^stage using mode_r; otherwise work unchanged.
  - Fill for SRL: vacated MSBs = 0.
  - Fill for SRA: vacated MSBs = copy of work[15] (sign of original In).
  - Fill for ROR: bits leaving LSB re-enter at MSB.
  - At E4 (stage=0): Out<=final shifted value, done<=1, busy<=0, state<=IDLE. Otherwise stage<=stage-1.
- Latency: fixed at 4 cycles from the accepting edge to the result, independent of Cnt.
  - Cnt=0 still takes 4 cycles; Out=In.
  - done is high for exactly the one cycle after E4; done<=0 on every other edge.
- busy: high in the cycles after E0 through E4; low in IDLE, including the done cycle.
- start while busy=1: ignored; captured operands are not disturbed.
- start in the done cycle: accepted (state is IDLE). Back-to-back throughput is one result per 5 cycles.
- Out update rule: Out changes only at E4 or on reset; intermediate work values are never visible on Out.
- Mode=11: identical to SRL.
- In/Cnt/Mode changing after E0: no effect on the current operation.

Test Plan:
1. SRL: In=0xF00F, Cnt=4, Mode=00, start for 1 cycle -> busy=1 for 4 cycles; done pulses for exactly 1 cycle; Out=0x0F00. With Cnt=15 on the same In -> Out=0x0001.
2. SRA:
   - In=0x8000, Cnt=15 -> Out=0xFFFF.
   - In=0x7FF0, Cnt=3 -> Out=0x0FFE.
   - In=0x8001, Cnt=1 -> Out=0xC000.
3. ROR: In=0x1234, Cnt=4 -> Out=0x4123. Then Cnt=0 -> Out=0x1234, still 4-cycle latency with done pulse.
4. Handshake: start held high continuously with In changing every cycle -> only the values at accepted edges (E0, then the done cycle) are used. Out=the first result until the second done. No extra done pulses.
5. Reset mid-op: assert rst at stage 1 of In=0xFFFF, Cnt=8, SRL -> Out=0, busy=0, done=0 immediately (asynchronous, before the next clk edge), with no later done pulse. Then release rst, In=0x00F0, Cnt=4 -> Out=0x000F.
6. Mode=11: In=0x8001, Cnt=1 -> Out=0x4000 (SRL behaviour).

Source files
------------

// File: rtl/shift_right_seq.sv
// Iterative 16-bit right shifter (SRL / SRA / ROR by 0..15).
// One binary stage (8, 4, 2, 1) is applied per clock, with a start/busy/done handshake.
module shift_right_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
    input  logic [1:0]  Mode,
    output logic [15:0] Out,
    output logic        busy,
    output logic        done
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [1:0] M_SRA = 2'b01;
    localparam logic [1:0] M_ROR = 2'b10;

    logic [0:0]  state;
    logic [1:0]  stage;
    logic [15:0] work;
    logic [3:0]  cnt_r;
    logic [1:0]  mode_r;

    logic [4:0]  amt;
    logic [31:0] rot;
    logic [15:0] shifted;
    logic [15:0] next_work;

    // Shift amount for the current stage is 2^stage; ROR is taken from a doubled word.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        amt       = 5'd1 << stage;
        rot       = {work, work} >> amt;
        shifted   = work >> amt;
        case (mode_r)
            M_SRA:   shifted = $signed(work) >>> amt;
            M_ROR:   shifted = rot[15:0];
            default: shifted = work >> amt;   // 00 and 11 both behave as SRL
        endcase
        next_work = cnt_r[stage] ? shifted : work;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            stage  <= 2'd3;
            work   <= 16'h0000;
            cnt_r  <= 4'd0;
            mode_r <= 2'b00;
            Out    <= 16'h0000;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work   <= In;
                        cnt_r  <= Cnt;
                        mode_r <= Mode;
                        stage  <= 2'd3;
                        state  <= SHIFT;
                        busy   <= 1'b1;
                    end
                end
                SHIFT: begin
                    work <= next_work;
                    if (stage == 2'd0) begin
                        Out   <= next_work;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        stage <= stage - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: vector table plus handshake and reset sequences,
// with expected results queued at stimulus time and popped on each done pulse.
module tb_shift_right_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic [1:0]  Mode;
    logic [15:0] Out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] sb[$];
    logic [15:0] last_exp;

    typedef struct {
        logic [15:0] a;
        logic [3:0]  cnt;
        logic [1:0]  mode;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    shift_right_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .In    (In),
        .Cnt   (Cnt),
        .Mode  (Mode),
        .Out   (Out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one single-bit step per count, independent of the staged hardware.
    function automatic logic [15:0] ref_shift(input logic [15:0] v, input logic [3:0] c,
                                              input logic [1:0] m);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < int'(c); i++) begin
            case (m)
                2'b01:   r = {r[15], r[15:1]};
                2'b10:   r = {r[0], r[15:1]};
                default: r = {1'b0, r[15:1]};
            endcase
        end
        return r;
    endfunction

    task automatic pop_compare(input string name);
        logic [15:0] e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({name, "_out"}, {16'h0, Out}, {16'h0, e});
            last_exp = e;
        end
    endtask

    // Single operation: start for one cycle, scramble inputs afterwards, expect done on the 5th negedge.
    task automatic run_op(input logic [15:0] a, input logic [3:0] c, input logic [1:0] m,
                          input logic [15:0] e, input string name);
        int lat;
        int seen;
        @(negedge clk);
        In = a; Cnt = c; Mode = m; start = 1'b1;
        sb.push_back(e);
        lat  = 0;
        seen = 0;
        for (int i = 1; i <= 10 && seen == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0; In = ~a; Cnt = ~c; Mode = ~m;
            end
            if (done) begin
                seen = 1;
                lat  = i;
            end else if (i < 5) begin
                check({name, "_busy"}, {31'd0, busy}, 32'd1);
                check({name, "_hold"}, {16'h0, Out}, {16'h0, last_exp});
            end
        end
        check({name, "_latency"}, lat, 5);
        if (seen != 0) begin
            check({name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
            pop_compare(name);
            @(negedge clk);
            check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
        end
    endtask

    logic [15:0] hs_vals[12];
    int          hs_done;
    int          seen3;
    logic [15:0] ra;
    logic [3:0]  rc;
    logic [1:0]  rm;

    initial begin
        vecs[0] = '{16'hF00F, 4'd4,  2'b00, 16'h0F00, "srl4"};
        vecs[1] = '{16'hF00F, 4'd15, 2'b00, 16'h0001, "srl15"};
        vecs[2] = '{16'h8000, 4'd15, 2'b01, 16'hFFFF, "sra15"};
        vecs[3] = '{16'h7FF0, 4'd3,  2'b01, 16'h0FFE, "sra3_pos"};
        vecs[4] = '{16'h8001, 4'd1,  2'b01, 16'hC000, "sra1_neg"};
        vecs[5] = '{16'h1234, 4'd4,  2'b10, 16'h4123, "ror4"};
        vecs[6] = '{16'h1234, 4'd0,  2'b10, 16'h1234, "ror0"};
        vecs[7] = '{16'h8001, 4'd1,  2'b11, 16'h4000, "mode11"};

        rst = 1'b1; start = 1'b0; In = 16'h0; Cnt = 4'd0; Mode = 2'b00;
        last_exp = 16'h0000;
        #2;
        check("reset_out",  {16'h0, Out}, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k])
            run_op(vecs[k].a, vecs[k].cnt, vecs[k].mode, vecs[k].exp, vecs[k].name);

        for (int k = 0; k < 4; k++) begin
            ra = 16'($urandom);
            rc = 4'($urandom_range(15, 0));
            rm = 2'($urandom_range(3, 0));
            run_op(ra, rc, rm, ref_shift(ra, rc, rm), "random");
        end

        // start held high with In changing every cycle: only the E0 and done-cycle values are taken.
        for (int j = 0; j < 12; j++) hs_vals[j] = 16'($urandom) | 16'h8000;
        hs_done = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done) begin
                hs_done++;
                pop_compare("hs");
            end else if (j != 0 && j != 11) begin
                check("hs_busy", {31'd0, busy}, 32'd1);
                check("hs_hold", {16'h0, Out}, {16'h0, last_exp});
            end
            In = hs_vals[j]; Cnt = 4'd4; Mode = 2'b00;
            start = (j < 11);
            if (j % 5 == 0) sb.push_back(ref_shift(hs_vals[j], 4'd4, 2'b00));
        end
        check("hs_done_count", hs_done, 2);
        seen3 = 0;
        for (int i = 0; i < 10 && seen3 == 0; i++) begin
            @(negedge clk);
            if (done) begin
                seen3 = 1;
                pop_compare("hs_third");
            end
        end
        check("hs_third_seen", seen3, 1);

        // Reset while stage=1: everything clears at once and no done follows.
        @(negedge clk);
        In = 16'hFFFF; Cnt = 4'd8; Mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_out",  {16'h0, Out}, 32'h0);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        check("rst_async_done", {31'd0, done}, 32'd0);
        last_exp = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_no_done", {31'd0, done}, 32'd0);
            check("rst_out_zero", {16'h0, Out}, 32'h0);
        end
        run_op(16'h00F0, 4'd4, 2'b00, 16'h000F, "post_rst");

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
